// File: rtl/servo_pkg.sv
// servo_pkg: shared servo PWM constants, default capture timing and capture FSM state type.
package servo_pkg;
    localparam logic [7:0] SERVO_NEUTRAL = 8'd128;
    localparam int MIN_CYCLES_DEF     = 100_000;
    localparam int STEP_CYCLES_DEF    = 391;
    localparam int GLITCH_CYCLES_DEF  = 50_000;
    localparam int MAXW_CYCLES_DEF    = 300_000;
    localparam int TIMEOUT_CYCLES_DEF = 2_500_000;
    typedef enum logic [1:0] {SYNC, IDLE, MEASURE} cap_state_t;
endpackage

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: 2-FF synchronizer with registered rise/fall strobes.
// ready marks when the synchronized level holds a real sample after reset.
module pwm_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic ready,
    output logic rise,
    output logic fall
);
    logic [1:0] sync_q, sync_d, vld_q, vld_d;
    logic rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        sync_d = {sync_q[0], din};
        vld_d  = {vld_q[0], 1'b1};
        rise_d = vld_q[1] & sync_q[0] & ~sync_q[1];
        fall_d = vld_q[1] & ~sync_q[0] & sync_q[1];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            vld_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            vld_q  <= vld_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    assign level = sync_q[1];
    assign ready = vld_q[1];
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/pwm_to_servo.sv
// pwm_to_servo: measures servo pulse high time and decodes it to an 8-bit command code.
// Define PWM_TO_SERVO_FAILSAFE_EN to force servo_out to neutral while the signal is lost.
module pwm_to_servo
    import servo_pkg::*;
#(
    parameter int MIN_CYCLES     = MIN_CYCLES_DEF,
    parameter int STEP_CYCLES    = STEP_CYCLES_DEF,
    parameter int GLITCH_CYCLES  = GLITCH_CYCLES_DEF,
    parameter int MAXW_CYCLES    = MAXW_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [7:0] servo_out,
    output logic       sample_valid,
    output logic       pulse_err,
    output logic       lost
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW  = $clog2(STEP_CYCLES + 1);
    localparam logic [18:0]    MIN_W     = 19'(MIN_CYCLES);
    localparam logic [18:0]    GLITCH_W  = 19'(GLITCH_CYCLES);
    localparam logic [18:0]    MAXW_W    = 19'(MAXW_CYCLES);
    localparam logic [FW-1:0]  STEP_LAST = FW'(STEP_CYCLES - 1);
    localparam logic [WDW-1:0] TO_W      = WDW'(TIMEOUT_CYCLES);

    logic line, ready, rise, fall, accept;
    cap_state_t state_q, state_d;
    logic [18:0] width_q, width_d;
    logic [FW-1:0] frac_q, frac_d;
    logic [7:0] code_q, code_d, servo_q, servo_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic sv_q, sv_d, pe_q, pe_d, lost_q, lost_d;

    pwm_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (line),
        .ready (ready),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        frac_d  = frac_q;
        code_d  = code_q;
        sv_d    = 1'b0;
        pe_d    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            SYNC: if (ready && !line) state_d = IDLE;
            IDLE: if (rise) begin
                state_d = MEASURE;
                width_d = 19'd1;
                frac_d  = '0;
                code_d  = '0;
            end
            MEASURE: if (fall) begin
                state_d = IDLE;
                accept  = width_q >= GLITCH_W;
                sv_d    = accept;
                pe_d    = !accept;
            end else if (width_q == MAXW_W) begin
                state_d = SYNC;
                pe_d    = 1'b1;
                width_d = width_q + 19'd1;
            end else begin
                width_d = (width_q == '1) ? width_q : width_q + 19'd1;
                // code tracks floor((W - MIN) / STEP) as W advances past MIN
                if (width_q >= MIN_W) begin
                    frac_d = (frac_q == STEP_LAST) ? '0 : frac_q + FW'(1);
                    code_d = (frac_q == STEP_LAST && code_q != 8'hff) ? code_q + 8'd1 : code_q;
                end
            end
            default: state_d = SYNC;
        endcase
        wd_d   = accept ? '0 : (wd_q == TO_W ? wd_q : wd_q + WDW'(1));
        lost_d = !accept && (lost_q || wd_d == TO_W);
`ifdef PWM_TO_SERVO_FAILSAFE_EN
        servo_d = accept ? code_q : (lost_d ? SERVO_NEUTRAL : servo_q);
`else
        servo_d = accept ? code_q : servo_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
            width_q <= '0;
            frac_q  <= '0;
            code_q  <= '0;
            servo_q <= SERVO_NEUTRAL;
            wd_q    <= '0;
            sv_q    <= 1'b0;
            pe_q    <= 1'b0;
            lost_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            frac_q  <= frac_d;
            code_q  <= code_d;
            servo_q <= servo_d;
            wd_q    <= wd_d;
            sv_q    <= sv_d;
            pe_q    <= pe_d;
            lost_q  <= lost_d;
        end
    end

    assign servo_out    = servo_q;
    assign sample_valid = sv_q;
    assign pulse_err    = pe_q;
    assign lost         = lost_q;
endmodule
